// File: rtl/gci_hub_specialmem_port.sv
// Master-side access port for the GCI hub special memory: range/alignment check,
// one-cycle read issue, timeout guard, held response and saturating error count.
module gci_hub_specialmem_port #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned TIMEOUT   = 16
)(
   input  logic        iCLOCK,
   input  logic        iRESET,
   input  logic        iMASTER_REQ,
   output logic        oMASTER_BUSY,
   input  logic        iMASTER_RW,
   input  logic [31:0] iMASTER_ADDR,
   input  logic [31:0] iMASTER_DATA,
   output logic        oMASTER_VALID,
   output logic        oMASTER_ERR,
   output logic [31:0] oMASTER_DATA,
   input  logic        iMASTER_LOCK,
   output logic        oSM_REQ,
   output logic [9:0]  oSM_ADDR,
   input  logic        iSM_VALID,
   input  logic [31:0] iSM_DATA,
   output logic [7:0]  oERR_COUNT
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      r_state, w_next;
   logic [9:0]  r_addr;
   logic [7:0]  r_tmo;
   logic [31:0] r_data;
   logic        r_err;
   logic        r_sm_req;
   logic        r_valid;
   logic [7:0]  r_err_cnt;
   logic        w_req_err;
   logic        w_resp_err;
   logic        w_enter_resp;
   logic        w_unused;

   // The window is read-only, so write data never reaches the datapath.
   assign w_unused  = ^iMASTER_DATA;
   assign w_req_err = iMASTER_RW | (iMASTER_ADDR[1:0] != 2'b00) |
                      (iMASTER_ADDR[31:10] != BASE_ADDR[31:10]);

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_resp_err = 1'b0;
      case (r_state)
         IDLE: if (iMASTER_REQ) begin
            if (w_req_err) begin
               w_next     = RESP;
               w_resp_err = 1'b1;
            end else begin
               w_next = ISSUE;
            end
         end
         ISSUE: w_next = iSM_VALID ? RESP : WAIT;
         WAIT: begin
            if (iSM_VALID) begin
               w_next = RESP;
            end else if (r_tmo == 8'd0) begin
               w_next     = RESP;
               w_resp_err = 1'b1;
            end
         end
         RESP: if (!iMASTER_LOCK) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         r_addr    <= 10'd0;
         r_tmo     <= 8'd0;
         r_data    <= 32'd0;
         r_err     <= 1'b0;
         r_sm_req  <= 1'b0;
         r_valid   <= 1'b0;
         r_err_cnt <= 8'd0;
      end else begin
         r_sm_req <= (w_next == ISSUE);
         r_valid  <= (w_next == RESP);
         // Offset doubles as the registered memory address: live only in ISSUE/WAIT.
         if (r_state == IDLE && w_next == ISSUE) r_addr <= iMASTER_ADDR[9:0];
         else if (w_next != ISSUE && w_next != WAIT) r_addr <= 10'd0;
         if (r_state == ISSUE && !iSM_VALID)
            r_tmo <= 8'(TIMEOUT - 1);
         else if (r_state == WAIT && !iSM_VALID && r_tmo != 8'd0)
            r_tmo <= r_tmo - 8'd1;
         if (w_enter_resp) begin
            r_err  <= w_resp_err;
            r_data <= w_resp_err ? 32'd0 : iSM_DATA;
         end else if (r_state == RESP && w_next == IDLE) begin
            r_err  <= 1'b0;
            r_data <= 32'd0;
         end
         if (w_enter_resp && w_resp_err && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign oMASTER_BUSY  = (r_state != IDLE);
   assign oMASTER_VALID = r_valid;
   assign oMASTER_ERR   = r_err;
   assign oMASTER_DATA  = r_data;
   assign oSM_REQ       = r_sm_req;
   assign oSM_ADDR      = r_addr;
   assign oERR_COUNT    = r_err_cnt;

endmodule

// File: tb/tb_gci_hub_specialmem_port.sv
// Randomized bench for gci_hub_specialmem_port: per-transaction reference model of
// classification, response latency, data and error count.
module tb_gci_hub_specialmem_port;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, rw, lock, sm_valid;
   logic [31:0] addr, wdata, sm_data;
   logic        busy, mvalid, merr, sm_req;
   logic [31:0] mdata;
   logic [9:0]  sm_addr;
   logic [7:0]  err_cnt;

   int          n_chk = 0, n_pass = 0;
   int          exp_cnt = 0;
   logic [31:0] smem [0:255];

   always #5 clk = ~clk;

   gci_hub_specialmem_port #(.BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
      .iCLOCK(clk), .iRESET(rst),
      .iMASTER_REQ(req), .oMASTER_BUSY(busy), .iMASTER_RW(rw),
      .iMASTER_ADDR(addr), .iMASTER_DATA(wdata),
      .oMASTER_VALID(mvalid), .oMASTER_ERR(merr), .oMASTER_DATA(mdata),
      .iMASTER_LOCK(lock), .oSM_REQ(sm_req), .oSM_ADDR(sm_addr),
      .iSM_VALID(sm_valid), .iSM_DATA(sm_data), .oERR_COUNT(err_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   // d: cycle offset after ISSUE at which the memory answers (-1 = never).
   task automatic run_txn(input logic t_rw, input logic [31:0] t_addr, input int d,
                          input int stall, input bit extra);
      logic        rej, e_err;
      logic [31:0] e_data;
      int          e_cyc, c;
      bit          got;
      rej   = t_rw || (t_addr[1:0] != 2'b00) || (t_addr[31:10] != BASE[31:10]);
      if (rej) begin
         e_cyc = 1; e_err = 1'b1;
      end else if (d >= 0 && d <= TO) begin
         e_cyc = 2 + d; e_err = 1'b0;
      end else begin
         e_cyc = TO + 2; e_err = 1'b1;
      end
      e_data = e_err ? 32'd0 : smem[t_addr[9:2]];
      if (e_err && exp_cnt < 255) exp_cnt++;

      req = 1'b1; rw = t_rw; addr = t_addr; wdata = $urandom;
      @(negedge clk);
      req = 1'b0; addr = $urandom; c = 1; got = 1'b0;
      while (c < 40 && !got) begin
         if (mvalid) begin
            got = 1'b1;
         end else begin
            chk("busy_wait", 32'(busy), 32'd1);
            chk("sm_req", 32'(sm_req), 32'((c == 1) && !rej));
            if (c == 1 && !rej) chk("sm_addr", 32'(sm_addr), 32'(t_addr[9:0]));
            sm_valid = !rej && (c == 1 + d);
            sm_data  = sm_valid ? smem[sm_addr[9:2]] : $urandom;
            @(negedge clk);
            c++;
         end
      end
      sm_valid = 1'b0;
      chk("latency", 32'(c), 32'(e_cyc));
      chk("resp_err", 32'(merr), 32'(e_err));
      chk("resp_data", mdata, e_data);
      chk("err_count", 32'(err_cnt), 32'(exp_cnt));
      for (int s = 0; s < stall; s++) begin
         lock = 1'b1;
         if (extra) begin
            req = 1'b1; rw = 1'b0; addr = {BASE[31:10], 10'h0};
         end
         @(negedge clk);
         chk("hold_valid", 32'(mvalid), 32'd1);
         chk("hold_data", mdata, e_data);
         chk("hold_err", 32'(merr), 32'(e_err));
         chk("hold_busy", 32'(busy), 32'd1);
         chk("hold_smreq", 32'(sm_req), 32'd0);
      end
      lock = 1'b0; req = 1'b0;
      @(negedge clk);
      chk("consumed_valid", 32'(mvalid), 32'd0);
      chk("consumed_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      int          sel;
      for (int i = 0; i < 256; i++) smem[i] = $urandom;
      smem[0]  = 32'h4;
      smem[65] = 32'h0000_0007;
      rst = 1'b1; req = 1'b0; rw = 1'b0; addr = 32'd0; wdata = 32'd0;
      lock = 1'b0; sm_valid = 1'b0; sm_data = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(mvalid), 32'd0);
      chk("rst_data", mdata, 32'd0);
      chk("rst_smreq", 32'(sm_req), 32'd0);
      chk("rst_errcnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_txn(1'b0, BASE + 32'h0, 0, 0, 1'b0);
      run_txn(1'b0, BASE + 32'h104, 0, 5, 1'b1);
      run_txn(1'b1, BASE + 32'h4, 0, 0, 1'b0);
      run_txn(1'b0, BASE + 32'h6, 0, 0, 1'b0);
      run_txn(1'b0, BASE + 32'h400, 0, 0, 1'b0);
      chk("three_errors", 32'(err_cnt), 32'd3);
      run_txn(1'b0, BASE + 32'h20, -1, 1, 1'b0);
      run_txn(1'b0, BASE + 32'h20, 9, 0, 1'b0);
      run_txn(1'b0, BASE + 32'h8, 2, 0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 9);
         a   = {BASE[31:10], 8'($urandom), 2'b00};
         if (sel == 0) a[1:0] = 2'($urandom_range(1, 3));
         if (sel == 1) a = $urandom | 32'h400;
         run_txn(($urandom % 6) == 0, a, $urandom_range(0, 21) - 1,
                 $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      end

      for (int i = 0; i < 300; i++) run_txn(1'b1, BASE + 32'h4, 0, 0, 1'b0);
      chk("saturated", 32'(err_cnt), 32'hFF);

      // Asynchronous reset while the port waits on the memory.
      req = 1'b1; rw = 1'b0; addr = BASE + 32'h10;
      @(negedge clk);
      req = 1'b0;
      repeat (4) @(negedge clk);
      chk("in_wait_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_valid", 32'(mvalid), 32'd0);
      chk("arst_err", 32'(merr), 32'd0);
      chk("arst_data", mdata, 32'd0);
      chk("arst_smreq", 32'(sm_req), 32'd0);
      chk("arst_smaddr", 32'(sm_addr), 32'd0);
      chk("arst_errcnt", 32'(err_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0; exp_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (mvalid || busy) chk("post_rst_quiet", {30'd0, mvalid, busy}, 32'd0);
      end
      chk("post_rst_valid", 32'(mvalid), 32'd0);
      run_txn(1'b0, BASE + 32'h0, 0, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/gci_hub_specialmem_port.md
Name: gci_hub_specialmem_port

Overview:
Master-side access port for the GCI hub special memory. It sits directly upstream of gci_hub_specialmem, the combinational node-info table (node count, total memory size, per-node usemem and priority). The port accepts single-word requests from the hub master bus, range- and alignment-checks them, and issues a one-cycle read to the special memory. It captures the returned word and holds it as a response on the master bus under back-pressure, with a timeout guard and a saturating error counter.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the 1 KiB special-memory window (must be 1 KiB aligned).
TIMEOUT, 16, number of cycles to wait for read valid before an error response is returned (range 1..255).

Ports:
iCLOCK  in  1  system clock, rising edge
iRESET  in  1  asynchronous active-high reset
iMASTER_REQ  in  1  request strobe, accepted when oMASTER_BUSY=0
oMASTER_BUSY  out  1  port cannot accept a request
iMASTER_RW  in  1  1=write, 0=read
iMASTER_ADDR  in  32  byte address
iMASTER_DATA  in  32  write data (ignored; window is read-only)
oMASTER_VALID  out  1  response valid, held until consumed
oMASTER_ERR  out  1  response is an error, qualified by oMASTER_VALID
oMASTER_DATA  out  32  response data
iMASTER_LOCK  in  1  downstream stall; response consumed on a cycle with oMASTER_VALID=1 and iMASTER_LOCK=0
oSM_REQ  out  1  special-memory read request (drives iREAD_REQ)
oSM_ADDR  out  10  special-memory offset (drives iREAD_ADDR)
iSM_VALID  in  1  special-memory data valid
iSM_DATA  in  32  special-memory data
oERR_COUNT  out  8  saturating count of error responses

Behaviour:
- Reset state: all outputs 0; state IDLE; latched address, data and timeout counter 0. Reset is asynchronous and active-high; the clock is iCLOCK and the reset is iRESET.
- Reset asserted mid-transaction aborts it immediately: no response is produced, and oERR_COUNT is cleared.
- States: IDLE, ISSUE, WAIT, RESP.
- oMASTER_BUSY = 1 in every state except IDLE.
- IDLE: on iMASTER_REQ=1, latch RW and ADDR, then classify:
  - error if RW=1, or ADDR[1:0]!=0, or ADDR[31:10]!=BASE_ADDR[31:10];
  - error requests go directly to RESP with ERR=1 and DATA=0;
  - otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - oSM_REQ=1, oSM_ADDR=ADDR[9:0] (registered outputs, low in all other states);
  - if iSM_VALID=1 in this cycle: capture iSM_DATA, go to RESP with ERR=0;
  - else load timeout counter with TIMEOUT-1 and go to WAIT.
- WAIT: oSM_REQ=0, oSM_ADDR held.
  - iSM_VALID=1: capture data, go to RESP with ERR=0;
  - else if counter==0: go to RESP with ERR=1 and DATA=32'h0;
  - else decrement the counter.
- RESP: oMASTER_VALID=1; DATA and ERR are stable until consumed.
  - On iMASTER_LOCK=0, go to IDLE; oMASTER_VALID drops the next cycle.
- Latency, valid read, no stall: request in cycle 0 → ISSUE in cycle 1 → oMASTER_VALID in cycle 2 → IDLE in cycle 3. Throughput is one request per 3 cycles.
- Error path latency: request in cycle 0 → oMASTER_VALID in cycle 1.
- iMASTER_REQ while busy is ignored; no queueing.
- oERR_COUNT increments by 1 on the cycle the port enters RESP with ERR=1, and saturates at 8'hFF.
- iSM_VALID seen in IDLE or RESP is ignored.
- Reads of unimplemented offsets (e.g. 10'h8) are not errors: they return whatever the special memory gives (0).

Test Plan:
- Valid read, BASE_ADDR=0, iSM_VALID=iSM_REQ loopback with iSM_DATA=32'h4 at offset 0: REQ ADDR=0 → oSM_REQ=1 / oSM_ADDR=0 in cycle 1; oMASTER_VALID=1, DATA=32'h4, ERR=0 in cycle 2.
- Back-pressure: read offset 10'h104 returning 32'h0000_0007, iMASTER_LOCK=1 for 5 cycles → VALID/DATA held 6 cycles; BUSY=1 throughout; a second REQ during the stall is ignored.
- Errors:
  - write to 0x4 → VALID in cycle 1, ERR=1, DATA=0, oSM_REQ never asserted;
  - ADDR=0x6 → ERR=1;
  - ADDR=0x400 → ERR=1;
  - oERR_COUNT=3 after all three.
- Timeout, TIMEOUT=16, iSM_VALID tied 0: ERR=1 response with oMASTER_VALID first high in cycle 18 after REQ (ISSUE in cycle 1, WAIT in cycles 2..17, RESP in cycle 18). A repeat with iSM_VALID pulsed in cycle 10 returns data with ERR=0.
- Saturation and reset: 300 invalid writes → oERR_COUNT=8'hFF. Asserting iRESET asynchronously while in WAIT → all outputs 0 immediately and no response follows.
